// File: rtl/pwm_multichannel.sv
// pwm_multichannel: N-channel double-buffered PWM generator with tick prescaler and optional phase stagger
// Ports:
//   clk, reset     system clock; asynchronous active-high reset clearing all state
//   enable         1 = run counters; 0 = hold counters at 0, outputs low, active tracks shadow
//   presc          one counter tick every presc+1 clk cycles
//   stagger        1 = channel k phase-shifted by k*2^WIDTH/CHANNELS ticks
//   duty_wr        strobe writing duty_data into shadow[duty_sel]
//   duty_sel       target channel of a duty write
//   duty_data      new duty value
//   pwm_out        registered PWM outputs, bit k = channel k
//   period_start   one-clk pulse aligned with the main counter wrapping to 0
module pwm_multichannel #(
    parameter int CHANNELS = 4,
    parameter int WIDTH = 8,
    parameter int PRESC_W = 4,
    localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PRESC_W-1:0]  presc,
    input  logic                stagger,
    input  logic                duty_wr,
    input  logic [SEL_W-1:0]    duty_sel,
    input  logic [WIDTH-1:0]    duty_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);
    localparam int OFF = (1 << WIDTH) / CHANNELS;
    logic [PRESC_W-1:0] pc;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] active [CHANNELS];
    logic [WIDTH-1:0] ph [CHANNELS];
    logic [CHANNELS-1:0] pwm_nxt;
    logic tick, boundary, wr_ok;
    assign tick = enable && pc == presc;
    assign boundary = tick && cnt == '1;
    assign wr_ok = duty_wr && 32'(duty_sel) < CHANNELS;
    always_comb begin
        pwm_nxt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            ph[k] = cnt + (stagger ? WIDTH'(k * OFF) : '0);
            pwm_nxt[k] = ph[k] < active[k];
        end
    end
    // pc > presc after a live presc change falls back to 0 on the next clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
            cnt <= '0;
            pwm_out <= '0;
            period_start <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            pc <= (!enable || pc >= presc) ? '0 : pc + 1'b1;
            cnt <= !enable ? '0 : cnt + WIDTH'(tick);
            pwm_out <= enable ? pwm_nxt : '0;
            period_start <= boundary;
            for (int k = 0; k < CHANNELS; k++)
                if (!enable || boundary) active[k] <= shadow[k];
            if (wr_ok) shadow[duty_sel] <= duty_data;
        end
    end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed plus randomized checks of pwm_multichannel against a tick-level reference model
module tb_pwm_multichannel;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, stagger = 1'b0, duty_wr = 1'b0;
    logic [3:0] presc = '0;
    logic [1:0] duty_sel = '0;
    logic [7:0] duty_data = '0;
    logic [3:0] pwm_out;
    logic period_start;
    int checks = 0, errors = 0;
    int m_pc, m_cnt;
    int m_sh[4], m_act[4];
    logic [3:0] m_pwm;
    logic m_ps;

    always #5 clk = ~clk;

    pwm_multichannel #(.CHANNELS(4), .WIDTH(8), .PRESC_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .presc(presc), .stagger(stagger),
        .duty_wr(duty_wr), .duty_sel(duty_sel), .duty_data(duty_data),
        .pwm_out(pwm_out), .period_start(period_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_pc = 0; m_cnt = 0; m_pwm = '0; m_ps = 1'b0;
        for (int k = 0; k < 4; k++) begin m_sh[k] = 0; m_act[k] = 0; end
    endtask

    // Spec rules evaluated on the values held just before the clock edge
    task automatic model_edge();
        int tick;
        int nsh[4];
        if (reset) begin model_clear(); return; end
        nsh = m_sh;
        if (duty_wr) nsh[duty_sel] = int'(duty_data);
        if (!enable) begin
            m_act = m_sh; m_pwm = '0; m_ps = 1'b0; m_pc = 0; m_cnt = 0;
        end else begin
            tick = (m_pc == int'(presc)) ? 1 : 0;
            for (int k = 0; k < 4; k++)
                m_pwm[k] = ((m_cnt + (stagger ? k * 64 : 0)) % 256) < m_act[k];
            m_ps = (tick == 1) && (m_cnt == 255);
            if (m_ps) m_act = m_sh;
            m_cnt = (m_cnt + tick) % 256;
            m_pc = (m_pc >= int'(presc)) ? 0 : m_pc + 1;
        end
        m_sh = nsh;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("period_start", 32'(period_start), 32'(m_ps));
    endtask

    task automatic wr(input int ch, input int d);
        duty_sel = 2'(ch); duty_data = 8'(d); duty_wr = 1'b1;
        step();
        duty_wr = 1'b0;
    endtask

    task automatic wait_ps(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = period_start;
        end
        check("period_start_timeout", 32'(seen), 32'd1);
    endtask

    task automatic window(input int n, input int wr_at, input int wr_ch, input int wr_d,
                          output int hi[4], output int rise[4], output int nps, output logic last_ps);
        logic [3:0] prev;
        prev = pwm_out;
        nps = 0;
        last_ps = 1'b0;
        for (int k = 0; k < 4; k++) begin hi[k] = 0; rise[k] = -1; end
        for (int i = 1; i <= n; i++) begin
            if (i == wr_at) begin duty_sel = 2'(wr_ch); duty_data = 8'(wr_d); duty_wr = 1'b1; end
            step();
            duty_wr = 1'b0;
            for (int k = 0; k < 4; k++) begin
                hi[k] += int'(pwm_out[k]);
                if (rise[k] < 0 && pwm_out[k] && !prev[k]) rise[k] = i;
            end
            prev = pwm_out;
            nps += int'(period_start);
            last_ps = period_start;
        end
    endtask

    task automatic interval(input int budget, output int len, output int hi1);
        bit seen = 0;
        len = 0; hi1 = 0;
        while (!seen && len < budget) begin
            step();
            len++;
            hi1 += int'(pwm_out[1]);
            seen = period_start;
        end
        check("interval_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int hi[4], rise[4], nps, len, hi1, p;
        int d[4];
        logic lps;
        model_clear();
        // Reset defaults, then two enabled periods with all duties at 0
        repeat (3) step();
        reset = 1'b0; enable = 1'b1;
        window(512, -1, 0, 0, hi, rise, nps, lps);
        for (int k = 0; k < 4; k++) check("reset_idle_hi", 32'(hi[k]), 32'd0);
        check("reset_idle_nps", 32'(nps), 32'd2);
        // Duty sweep
        wr(0, 0); wr(1, 1); wr(2, 128); wr(3, 255);
        wait_ps(600);
        window(256, -1, 0, 0, hi, rise, nps, lps);
        check("sweep_ch0", 32'(hi[0]), 32'd0);
        check("sweep_ch1", 32'(hi[1]), 32'd1);
        check("sweep_ch2", 32'(hi[2]), 32'd128);
        check("sweep_ch3", 32'(hi[3]), 32'd255);
        check("sweep_ps", 32'(lps), 32'd1);
        // Double buffering: mid-period write, then a write landing on the boundary edge
        wr(0, 64);
        wait_ps(600);
        window(256, 100, 0, 200, hi, rise, nps, lps);
        check("dbuf_cur", 32'(hi[0]), 32'd64);
        window(256, 256, 0, 30, hi, rise, nps, lps);
        check("dbuf_next", 32'(hi[0]), 32'd200);
        window(256, -1, 0, 0, hi, rise, nps, lps);
        check("dbuf_bnd_hold", 32'(hi[0]), 32'd200);
        window(256, -1, 0, 0, hi, rise, nps, lps);
        check("dbuf_bnd_apply", 32'(hi[0]), 32'd30);
        // Randomized duties, prescaler and stagger
        for (int r = 0; r < 3; r++) begin
            p = int'($urandom_range(0, 3));
            presc = 4'(p);
            stagger = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                d[k] = int'($urandom_range(0, 255));
                wr(k, d[k]);
            end
            wait_ps(5000);
            window(256 * (p + 1), -1, 0, 0, hi, rise, nps, lps);
            for (int k = 0; k < 4; k++) check("rand_hi", 32'(hi[k]), 32'(d[k] * (p + 1)));
            check("rand_ps", 32'(lps), 32'd1);
        end
        // Prescaler 3, then live change back to 0
        stagger = 1'b0;
        wr(1, 10);
        presc = 4'd3;
        wait_ps(5000);
        interval(5000, len, hi1);
        check("presc3_len", 32'(len), 32'd1024);
        check("presc3_ch1", 32'(hi1), 32'd40);
        presc = 4'd0;
        wait_ps(5000);
        interval(5000, len, hi1);
        check("presc0_len", 32'(len), 32'd256);
        check("presc0_ch1", 32'(hi1), 32'd10);
        // Stagger: turn-on edges spread a quarter period apart
        for (int k = 0; k < 4; k++) wr(k, 32);
        stagger = 1'b1;
        wait_ps(600);
        window(256, -1, 0, 0, hi, rise, nps, lps);
        for (int k = 0; k < 4; k++) check("stagger_hi", 32'(hi[k]), 32'd32);
        check("stagger_rise0", 32'(rise[0]), 32'd1);
        check("stagger_rise1", 32'(rise[1]), 32'd193);
        check("stagger_rise2", 32'(rise[2]), 32'd129);
        check("stagger_rise3", 32'(rise[3]), 32'd65);
        // Disabled write, then re-enable: new duty from the first period, no early period_start
        enable = 1'b0; stagger = 1'b0;
        step(); step();
        wr(2, 77);
        step();
        check("disabled_out", 32'(pwm_out), 32'd0);
        enable = 1'b1;
        window(256, -1, 0, 0, hi, rise, nps, lps);
        check("en_ch0", 32'(hi[0]), 32'd32);
        check("en_ch1", 32'(hi[1]), 32'd32);
        check("en_ch2", 32'(hi[2]), 32'd77);
        check("en_ch3", 32'(hi[3]), 32'd32);
        check("en_nps", 32'(nps), 32'd1);
        check("en_last_ps", 32'(lps), 32'd1);
        // Asynchronous reset mid-period while outputs are high
        window(10, -1, 0, 0, hi, rise, nps, lps);
        check("pre_reset_high", 32'(pwm_out), 32'hf);
        #3 reset = 1'b1;
        #1;
        check("async_pwm", 32'(pwm_out), 32'd0);
        check("async_ps", 32'(period_start), 32'd0);
        model_clear();
        step(); step();
        reset = 1'b0;
        window(512, -1, 0, 0, hi, rise, nps, lps);
        for (int k = 0; k < 4; k++) check("post_reset_hi", 32'(hi[k]), 32'd0);
        check("post_reset_nps", 32'(nps), 32'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
